// File: rtl/microcode_sequencer.sv
// Microcode sequencer: fetches microwords from microcode_rom and walks NEXT/JUMP/BRANCH/END.
// Optional step watchdog enabled by defining VTX1_MCSEQ_WATCHDOG_EN.
module microcode_sequencer #(
  parameter int ADDR_W    = 10,
  parameter int CTRL_W    = 16,
  parameter int MAX_STEPS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] entry_addr,
  input  logic              abort,
  input  logic [15:0]       cond_in,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              ctrl_valid,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [ADDR_W-1:0] upc,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_enable,
  input  logic [31:0]       rom_data,
  input  logic              rom_ready,
  input  logic              rom_error
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
  typedef enum logic [1:0] {SEQ_NEXT, SEQ_JUMP, SEQ_BRANCH, SEQ_END} seq_t;

  state_t            state;
  seq_t              seq_q;
  logic [ADDR_W-1:0] tgt_q;
  logic [3:0]        sel_q;
  logic              taken;
  logic [ADDR_W-1:0] npc;
  logic              upc_ovf;
  logic              wd_hit;

  always_comb begin
    taken   = (seq_q == SEQ_JUMP) || ((seq_q == SEQ_BRANCH) && cond_in[sel_q]);
    npc     = taken ? tgt_q : upc + ADDR_W'(1);
    // sequential advance off the top of the ROM is an error, never a wrap
    upc_ovf = !taken && (upc == {ADDR_W{1'b1}});
  end

`ifdef VTX1_MCSEQ_WATCHDOG_EN
  localparam logic [8:0] WD_LAST = 9'(MAX_STEPS - 1);
  logic [8:0] steps;
  assign wd_hit = (steps == WD_LAST);
`else
  logic unused_max_steps;
  assign unused_max_steps = (MAX_STEPS > 0);
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      seq_q      <= SEQ_NEXT;
      tgt_q      <= '0;
      sel_q      <= '0;
      ctrl_out   <= '0;
      ctrl_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      upc        <= '0;
      rom_addr   <= '0;
      rom_enable <= 1'b0;
`ifdef VTX1_MCSEQ_WATCHDOG_EN
      steps      <= '0;
`endif
    end else begin
      ctrl_valid <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      case (state)
        IDLE: if (start) begin
          upc        <= entry_addr;
          rom_addr   <= entry_addr;
          rom_enable <= 1'b1;
          busy       <= 1'b1;
          state      <= FETCH;
`ifdef VTX1_MCSEQ_WATCHDOG_EN
          steps      <= '0;
`endif
        end
        FETCH: begin
          if (abort) begin
            rom_enable <= 1'b0;
            busy       <= 1'b0;
            fault      <= 1'b1;
            state      <= IDLE;
          end else if (rom_ready) begin
            rom_enable <= 1'b0;
            if (rom_error) begin
              busy  <= 1'b0;
              fault <= 1'b1;
              state <= IDLE;
            end else begin
              seq_q      <= seq_t'(rom_data[31:30]);
              tgt_q      <= rom_data[20 +: ADDR_W];
              sel_q      <= rom_data[19:16];
              ctrl_out   <= rom_data[CTRL_W-1:0];
              ctrl_valid <= 1'b1;
              state      <= EXEC;
            end
          end
        end
        EXEC: begin
`ifdef VTX1_MCSEQ_WATCHDOG_EN
          steps <= steps + 9'd1;
`endif
          if (abort || (seq_q != SEQ_END && (wd_hit || upc_ovf))) begin
            busy  <= 1'b0;
            fault <= 1'b1;
            state <= IDLE;
          end else if (seq_q == SEQ_END) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            upc        <= npc;
            rom_addr   <= npc;
            rom_enable <= 1'b1;
            state      <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Scoreboard bench for microcode_sequencer: ROM responder model, expected fetch/ctrl/end queues.
module tb_microcode_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [9:0]  entry_addr = '0;
  logic [15:0] cond_in = '0;
  logic [15:0] ctrl_out;
  logic        ctrl_valid, busy, done, fault, rom_enable;
  logic [9:0]  upc, rom_addr;
  logic [31:0] rom_data = '0;
  logic        rom_ready = 1'b0, rom_error = 1'b0;

  logic [31:0] mem [0:1023];
  logic [31:0] q_fetch[$], q_ctrl[$], q_end[$];
  int          n_tests = 0, n_fail = 0, n_exec = 0, rom_lat = 0, base;
  bit          stall = 0, err_en = 0, pulse_req = 0;
  logic [9:0]  err_addr = '0;

  localparam logic [1:0] NXT = 2'b00, JMP = 2'b01, BRA = 2'b10, ENDW = 2'b11;
  localparam logic [31:0] K_DONE = 32'd2, K_FAULT = 32'd1;

  microcode_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .entry_addr(entry_addr), .abort(abort),
    .cond_in(cond_in), .ctrl_out(ctrl_out), .ctrl_valid(ctrl_valid), .busy(busy),
    .done(done), .fault(fault), .upc(upc), .rom_addr(rom_addr), .rom_enable(rom_enable),
    .rom_data(rom_data), .rom_ready(rom_ready), .rom_error(rom_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mw(input logic [1:0] s, input logic [9:0] t,
                                     input logic [3:0] c, input logic [15:0] k);
    return {s, t, c, k};
  endfunction

  // ROM model: ready after rom_lat wait cycles, error on err_addr when enabled
  initial begin : rom_model
    int  lat_cnt;
    bit  pulse_ack;
    lat_cnt = 0;
    pulse_ack = 0;
    forever begin
      @(negedge clk);
      if (pulse_req != pulse_ack) begin
        pulse_ack = pulse_req;
        rom_ready = 1'b1;
        rom_error = 1'b0;
        rom_data  = mem[10'h050];
      end else if (rom_enable && !rom_ready && !stall) begin
        if (lat_cnt >= rom_lat) begin
          rom_ready = 1'b1;
          rom_data  = mem[rom_addr];
          rom_error = err_en && (rom_addr == err_addr);
          lat_cnt   = 0;
        end else lat_cnt++;
      end else begin
        rom_ready = 1'b0;
        rom_error = 1'b0;
        if (!rom_enable) lat_cnt = 0;
      end
    end
  end

  // Scoreboard monitor: fetch starts, ctrl strobes and end pulses
  initial begin : monitor
    bit en_prev;
    en_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) en_prev = 0;
      else begin
        if (rom_enable && !en_prev) begin
          if (q_fetch.size() == 0) chk("fetch_unexpected", 32'(q_fetch.size()), 32'd1);
          else chk("fetch_addr", 32'(rom_addr), q_fetch.pop_front());
        end
        en_prev = rom_enable;
        if (ctrl_valid) begin
          n_exec++;
          chk("ctrl_vs_enable", 32'(rom_enable), 32'd0);
          if (q_ctrl.size() == 0) chk("ctrl_unexpected", 32'(q_ctrl.size()), 32'd1);
          else chk("ctrl_upc_word", {6'd0, upc, ctrl_out}, q_ctrl.pop_front());
        end
        if (done || fault) begin
          chk("end_busy", 32'(busy), 32'd0);
          if (q_end.size() == 0) chk("end_unexpected", 32'(q_end.size()), 32'd1);
          else chk("end_kind", {30'd0, done, fault}, q_end.pop_front());
        end
      end
    end
  end

  task automatic exp_fetch(input logic [9:0] a); q_fetch.push_back(32'(a)); endtask
  task automatic exp_ctrl(input logic [9:0] u, input logic [15:0] c);
    q_ctrl.push_back({6'd0, u, c});
  endtask

  task automatic do_start(input logic [9:0] a);
    @(negedge clk); start = 1'b1; entry_addr = a;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc && busy; i++) @(negedge clk);
    chk("idle_timeout", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    chk({tag, "_fetch_left"}, 32'(q_fetch.size()), 32'd0);
    chk({tag, "_ctrl_left"},  32'(q_ctrl.size()),  32'd0);
    chk({tag, "_end_left"},   32'(q_end.size()),   32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl_out", 32'(ctrl_out), 32'd0);
    chk("rst_outs", {25'd0, ctrl_valid, busy, done, fault, rom_enable, 2'd0}, 32'd0);
    chk("rst_upc", 32'(upc), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    rst_n = 1'b1;

    // NEXT, NEXT, END
    mem[0] = mw(NXT, 10'h0, 4'h0, 16'h0001);
    mem[1] = mw(NXT, 10'h0, 4'h0, 16'h0002);
    mem[2] = mw(ENDW, 10'h0, 4'h0, 16'h0003);
    for (int i = 0; i < 3; i++) begin exp_fetch(10'(i)); exp_ctrl(10'(i), 16'(i + 1)); end
    q_end.push_back(K_DONE);
    do_start(10'h000);
    wait_idle(50);
    drain("t1");

    // BRANCH taken / not taken on cond_in[3]
    rom_lat = 2;
    mem[10'h018] = mw(BRA, 10'h100, 4'd3, 16'h00B1);
    mem[10'h100] = mw(ENDW, 10'h0, 4'h0, 16'h00E1);
    mem[10'h019] = mw(ENDW, 10'h0, 4'h0, 16'h00E2);
    cond_in = 16'h0008;
    exp_fetch(10'h018); exp_fetch(10'h100);
    exp_ctrl(10'h018, 16'h00B1); exp_ctrl(10'h100, 16'h00E1);
    q_end.push_back(K_DONE);
    do_start(10'h018);
    wait_idle(50);
    cond_in = 16'hFFF7;
    exp_fetch(10'h018); exp_fetch(10'h019);
    exp_ctrl(10'h018, 16'h00B1); exp_ctrl(10'h019, 16'h00E2);
    q_end.push_back(K_DONE);
    do_start(10'h018);
    wait_idle(50);
    drain("t2");

    // ROM error on fetch
    err_en = 1; err_addr = 10'h3F0;
    mem[10'h3F0] = mw(ENDW, 10'h0, 4'h0, 16'hDEAD);
    exp_fetch(10'h3F0);
    q_end.push_back(K_FAULT);
    do_start(10'h3F0);
    wait_idle(50);
    err_en = 0;
    drain("t3");

    // NEXT off the top of the ROM, with a start while busy
    mem[10'h3FE] = mw(JMP, 10'h3FF, 4'h0, 16'h0041);
    mem[10'h3FF] = mw(NXT, 10'h0, 4'h0, 16'h0042);
    exp_fetch(10'h3FE); exp_fetch(10'h3FF);
    exp_ctrl(10'h3FE, 16'h0041); exp_ctrl(10'h3FF, 16'h0042);
    q_end.push_back(K_FAULT);
    do_start(10'h3FE);
    do_start(10'h000);
    wait_idle(50);
    drain("t4");
    rom_lat = 0;

    // abort while ROM stalls; late ready ignored
    stall = 1;
    mem[10'h050] = mw(ENDW, 10'h0, 4'h0, 16'h0050);
    exp_fetch(10'h050);
    do_start(10'h050);
    repeat (4) @(negedge clk);
    chk("t5_enable_held", 32'(rom_enable), 32'd1);
    abort = 1'b1;
    q_end.push_back(K_FAULT);
    @(negedge clk); abort = 1'b0;
    chk("t5_enable_drop", 32'(rom_enable), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    stall = 0;
    repeat (2) @(negedge clk);
    pulse_req = ~pulse_req;
    repeat (4) @(negedge clk);
    drain("t5");

    // abort in IDLE has no effect
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    drain("t5b");

    // JUMP-to-self loop
    mem[10'h020] = mw(JMP, 10'h020, 4'h0, 16'h0066);
    base = n_exec;
`ifdef VTX1_MCSEQ_WATCHDOG_EN
    for (int i = 0; i < 256; i++) begin exp_fetch(10'h020); exp_ctrl(10'h020, 16'h0066); end
    q_end.push_back(K_FAULT);
    do_start(10'h020);
    wait_idle(2000);
    chk("t6_exec_count", 32'(n_exec - base), 32'd256);
`else
    for (int i = 0; i < 310; i++) begin exp_fetch(10'h020); exp_ctrl(10'h020, 16'h0066); end
    do_start(10'h020);
    for (int i = 0; i < 1000 && (n_exec - base) < 300; i++) @(negedge clk);
    chk("t6_busy_300", 32'(busy), 32'd1);
    chk("t6_reached_300", 32'(n_exec - base >= 300), 32'd1);
    abort = 1'b1;
    q_end.push_back(K_FAULT);
    @(negedge clk); abort = 1'b0;
    wait_idle(10);
    q_fetch.delete(); q_ctrl.delete();
`endif
    drain("t6");

    // reset mid-op
    for (int i = 0; i < 20; i++) begin exp_fetch(10'h020); exp_ctrl(10'h020, 16'h0066); end
    do_start(10'h020);
    repeat (5) @(negedge clk);
    chk("t7_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t7_outs", {25'd0, ctrl_valid, busy, done, fault, rom_enable, 2'd0}, 32'd0);
    chk("t7_upc", 32'(upc), 32'd0);
    chk("t7_rom_addr", 32'(rom_addr), 32'd0);
    q_fetch.delete(); q_ctrl.delete();
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    drain("t7");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
